// File: rtl/spi_accel_slave_if.sv
// SPI pin bundle between the AHB SPI master and the accelerometer model.
// Signalling: mode 0 SPI. SCLK idles low, MOSI/MISO change after SCLK falls
// and are sampled on SCLK rise. A transfer is framed by CS_N low. There is
// no valid/ready pair; MISO is meaningful only while CS_N is low.
interface spi_accel_slave_if;
    logic SCLK;
    logic MOSI;
    logic CS_N;
    logic MISO;

    modport master (output SCLK, output MOSI, output CS_N, input MISO);
    modport slave  (input SCLK, input MOSI, input CS_N, output MISO);
endinterface

// File: rtl/spi_accel_slave.sv
// Behavioural SPI slave standing in for the board accelerometer. Oversamples
// the SPI pins in the HCLK domain, decodes the command/address/data protocol
// and serves a 64-byte register map with coherent sample shadows.
module spi_accel_slave (
    input  logic                HCLK,
    input  logic                HRESET,
    spi_accel_slave_if.slave    spi,
    input  logic [11:0]         SAMPLE_X,
    input  logic [11:0]         SAMPLE_Y,
    input  logic [11:0]         SAMPLE_Z,
    input  logic                SAMPLE_VALID,
    output logic [7:0]          POWER_CTL,
    output logic                XFER_ACTIVE,
    output logic [2:0]          dbg_state
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CMD     = 3'd1;
    localparam logic [2:0] S_ADDR    = 3'd2;
    localparam logic [2:0] S_DATA_WR = 3'd3;
    localparam logic [2:0] S_DATA_RD = 3'd4;
    localparam logic [2:0] S_IGNORE  = 3'd5;

    logic [2:0]  sclk_sync_q, sclk_sync_d;
    logic [2:0]  cs_sync_q, cs_sync_d;
    logic [1:0]  mosi_sync_q, mosi_sync_d;
    logic [2:0]  state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  rx_sh_q, rx_sh_d;
    logic [5:0]  addr_q, addr_d;
    logic        is_rd_q, is_rd_d;
    logic [7:0]  tx_sh_q, tx_sh_d;
    logic        wr_pend_q, wr_pend_d;
    logic        rd_pend_q, rd_pend_d;
    logic [11:0] x_live_q, x_live_d, y_live_q, y_live_d, z_live_q, z_live_d;
    logic [11:0] x_shd_q, x_shd_d, y_shd_q, y_shd_d, z_shd_q, z_shd_d;
    logic        data_ready_q, data_ready_d;
    logic [7:0]  cfg_q [16];
    logic [7:0]  cfg_d [16];

    logic        sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [7:0]  rx_byte;
    logic [7:0]  rd_data;

    // Bit 1 is the synchronised pin, bit 2 the previous value for edge detection.
    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
    assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
    assign rx_byte   = {rx_sh_q[6:0], mosi_sync_q[1]};

    assign spi.MISO    = (state_q != S_IDLE) & tx_sh_q[7];
    assign XFER_ACTIVE = (state_q != S_IDLE);
    assign POWER_CTL   = cfg_q[13];
    assign dbg_state   = state_q;

    // Register map read mux; sample registers come from the burst shadows.
    always_comb begin
        rd_data = 8'h00;
        case (addr_q)
            6'h00: rd_data = 8'hAD;
            6'h01: rd_data = 8'h1D;
            6'h02: rd_data = 8'hF2;
            6'h03: rd_data = 8'h01;
            6'h08: rd_data = x_shd_q[11:4];
            6'h09: rd_data = y_shd_q[11:4];
            6'h0A: rd_data = z_shd_q[11:4];
            6'h0B: rd_data = {7'b0, data_ready_q};
            6'h0E: rd_data = x_shd_q[7:0];
            6'h0F: rd_data = {{4{x_shd_q[11]}}, x_shd_q[11:8]};
            6'h10: rd_data = y_shd_q[7:0];
            6'h11: rd_data = {{4{y_shd_q[11]}}, y_shd_q[11:8]};
            6'h12: rd_data = z_shd_q[7:0];
            6'h13: rd_data = {{4{z_shd_q[11]}}, z_shd_q[11:8]};
            default: if (addr_q[5:4] == 2'b10) rd_data = cfg_q[addr_q[3:0]];
        endcase
    end

    // Next-state: pin sync, deferred commit/load of the last byte, samples, protocol FSM.
    always_comb begin
        sclk_sync_d  = {sclk_sync_q[1:0], spi.SCLK};
        cs_sync_d    = {cs_sync_q[1:0], spi.CS_N};
        mosi_sync_d  = {mosi_sync_q[0], spi.MOSI};
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        rx_sh_d      = rx_sh_q;
        addr_d       = addr_q;
        is_rd_d      = is_rd_q;
        tx_sh_d      = tx_sh_q;
        wr_pend_d    = 1'b0;
        rd_pend_d    = 1'b0;
        x_live_d     = x_live_q;
        y_live_d     = y_live_q;
        z_live_d     = z_live_q;
        x_shd_d      = x_shd_q;
        y_shd_d      = y_shd_q;
        z_shd_d      = z_shd_q;
        data_ready_d = data_ready_q;
        cfg_d        = cfg_q;

        // A byte completed last cycle: commit it, or fetch the next read byte.
        if (wr_pend_q) begin
            if (addr_q[5:4] == 2'b10) cfg_d[addr_q[3:0]] = rx_sh_q;
            if (addr_q == 6'h1F && rx_sh_q == 8'h52) begin
                for (int i = 0; i < 16; i++) cfg_d[i] = 8'h00;
                data_ready_d = 1'b0;
            end
            addr_d = addr_q + 6'd1;
        end
        if (rd_pend_q) begin
            tx_sh_d = rd_data;
            addr_d  = addr_q + 6'd1;
            if (addr_q == 6'h08 || addr_q == 6'h0E) data_ready_d = 1'b0;
        end

        // A new sample overrides any DATA_READY clear in the same cycle.
        if (SAMPLE_VALID) begin
            x_live_d     = SAMPLE_X;
            y_live_d     = SAMPLE_Y;
            z_live_d     = SAMPLE_Z;
            data_ready_d = 1'b1;
        end

        if (cs_rise) begin
            state_d   = S_IDLE;
            bit_cnt_d = 3'd0;
            tx_sh_d   = 8'h00;
        end else if (cs_fall) begin
            state_d   = S_CMD;
            bit_cnt_d = 3'd0;
            tx_sh_d   = 8'h00;
            x_shd_d   = x_live_q;
            y_shd_d   = y_live_q;
            z_shd_d   = z_live_q;
        end else if (state_q != S_IDLE) begin
            if (sclk_rise) begin
                rx_sh_d   = rx_byte;
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    case (state_q)
                        S_CMD: begin
                            if (rx_byte == 8'h0A) begin
                                state_d = S_ADDR;
                                is_rd_d = 1'b0;
                            end else if (rx_byte == 8'h0B) begin
                                state_d = S_ADDR;
                                is_rd_d = 1'b1;
                            end else begin
                                state_d = S_IGNORE;
                            end
                        end
                        S_ADDR: begin
                            addr_d    = rx_byte[5:0];
                            state_d   = is_rd_q ? S_DATA_RD : S_DATA_WR;
                            rd_pend_d = is_rd_q;
                        end
                        S_DATA_WR: wr_pend_d = 1'b1;
                        S_DATA_RD: rd_pend_d = 1'b1;
                        default: ;
                    endcase
                end
            end else if (sclk_fall && state_q == S_DATA_RD && bit_cnt_q != 3'd0) begin
                // Bit 7 of a freshly loaded byte is held across the byte boundary.
                tx_sh_d = {tx_sh_q[6:0], 1'b0};
            end
        end
    end

    // State registers; pin synchronisers reset to the idle pin levels.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            sclk_sync_q  <= 3'b000;
            cs_sync_q    <= 3'b111;
            mosi_sync_q  <= 2'b00;
            state_q      <= S_IDLE;
            bit_cnt_q    <= 3'd0;
            rx_sh_q      <= 8'h00;
            addr_q       <= 6'd0;
            is_rd_q      <= 1'b0;
            tx_sh_q      <= 8'h00;
            wr_pend_q    <= 1'b0;
            rd_pend_q    <= 1'b0;
            x_live_q     <= 12'd0;
            y_live_q     <= 12'd0;
            z_live_q     <= 12'd0;
            x_shd_q      <= 12'd0;
            y_shd_q      <= 12'd0;
            z_shd_q      <= 12'd0;
            data_ready_q <= 1'b0;
            for (int i = 0; i < 16; i++) cfg_q[i] <= 8'h00;
        end else begin
            sclk_sync_q  <= sclk_sync_d;
            cs_sync_q    <= cs_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_sh_q      <= rx_sh_d;
            addr_q       <= addr_d;
            is_rd_q      <= is_rd_d;
            tx_sh_q      <= tx_sh_d;
            wr_pend_q    <= wr_pend_d;
            rd_pend_q    <= rd_pend_d;
            x_live_q     <= x_live_d;
            y_live_q     <= y_live_d;
            z_live_q     <= z_live_d;
            x_shd_q      <= x_shd_d;
            y_shd_q      <= y_shd_d;
            z_shd_q      <= z_shd_d;
            data_ready_q <= data_ready_d;
            cfg_q        <= cfg_d;
        end
    end
endmodule
